event_encoder16: RTL and testbench
==================================

EVENT_ENCODER16 -- requirements
Module: event_encoder16

Interface
REQ-001 SHALL have parameter: RR_MODE, default 0, meaning 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  16  event strobes; bit i high for one clock = one event on line i.
REQ-005 SHALL have port: out_ready  input  1  consumer accepts out_idx this cycle.
REQ-006 SHALL have port: out_valid  output  1  out_idx holds a valid encoded event.
REQ-007 SHALL have port: out_idx  output  4  binary index of the granted event line (inverse of the 4-to-16 decode).
REQ-008 SHALL have port: pend  output  16  current pending-event register.
REQ-009 SHALL have port: overflow  output  1  one-cycle pulse: an event merged into an already-pending bit.

Function
REQ-010 SHALL update pend each edge as: pend_next = (pend & ~clr) | req, where clr is the one-hot of the index loaded into the output stage that cycle (zero if none).
REQ-011 SHALL let set win over clear: a req bit equal to the index being loaded leaves that bit pending as a new event.
REQ-012 SHALL define load = !out_valid || out_ready; the output stage updates only when load is high.
REQ-013 SHALL, when load and pend != 0, register out_idx = selected index, out_valid = 1, and clear that bit via clr.
REQ-014 SHALL, when load and pend == 0, register out_valid = 0; out_idx holds its previous value.
REQ-015 SHALL hold out_idx and out_valid stable while out_valid && !out_ready.
REQ-016 SHALL select from pend only (never directly from req); latency: req sampled at edge E, earliest out_valid high after edge E+1.
REQ-017 SHALL, in fixed mode, select the lowest set index of pend.
REQ-018 SHALL, in RR mode, select the first set bit searching upward from pointer ptr with wrap 15->0; after each grant of index k, ptr = (k+1) mod 16.
REQ-019 SHALL pulse overflow for one cycle when any req bit i is high while pend[i] is high and i is not the index being cleared that cycle.
REQ-020 SHALL sustain one grant per cycle when out_ready is held high and pend is nonzero.

Reset
REQ-021 SHALL, on rst_n low, asynchronously clear pend = 0, out_valid = 0, out_idx = 0, overflow = 0, ptr = 0.
REQ-022 SHALL discard all pending and in-flight events when reset asserts mid-operation; no event is reported after reset release unless re-requested.
REQ-023 SHALL ignore req during reset and resume sampling from the first rising edge after rst_n deasserts.

Structure
REQ-024 SHALL take constants EV_W = 16 and IDX_W = 4 from a shared package, together with a one-hot-to-index helper function.
REQ-025 SHALL use one combinational sub-module, ffs16_rot (rotate by ptr, find first set, add back ptr mod 16), shared by both modes (ptr tied to 0 in fixed mode).
REQ-026 SHALL contain no latches; every always block fully assigns its outputs.

Verification
REQ-027 SHALL check single event: req = 0x0020 for one cycle, out_ready = 1 -> out_valid high two edges later with out_idx = 5, pend back to 0.
REQ-028 SHALL check fixed priority: req = 0x8101, out_ready = 1 -> grants 0, 8, 15 on consecutive cycles, then out_valid = 0.
REQ-029 SHALL check round-robin: RR_MODE = 1, pend held at 0x0003 by repeated req, out_ready = 1 -> grants alternate 0, 1, 0, 1.
REQ-030 SHALL check backpressure: out_ready = 0 with out_idx = 3 valid, req = 0x0001 -> out_idx stays 3; after out_ready = 1, next grant = 0.
REQ-031 SHALL check overflow: pend[4] = 1 with output stalled, req = 0x0010 -> overflow pulses for one cycle and bit 4 is granted exactly once.
REQ-032 SHALL check reset mid-operation: pend = 0xFFFF, assert rst_n low asynchronously between edges -> all outputs 0 immediately, and no grants after release.

Source files
------------

// File: rtl/event_encoder16_pkg.sv
// Shared constants and helpers for the 16-line event encoder.
package event_encoder16_pkg;

    localparam int unsigned EV_W  = 16;
    localparam int unsigned IDX_W = 4;

    // OR of the indices of all set bits; exact for a one-hot input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [EV_W-1:0] onehot);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < EV_W; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/event_encoder16_ffs16_rot.sv
// Rotating find-first-set: first set bit of vec_i at or above ptr_i, wrapping 15 -> 0.
module ffs16_rot
    import event_encoder16_pkg::*;
(
    input  logic [EV_W-1:0]  vec_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*EV_W-1:0] dbl;
    logic [EV_W-1:0]   rot;
    logic [EV_W-1:0]   lowest;

    always_comb begin
        // rot[j] = vec_i[(j + ptr_i) mod 16]
        dbl     = {vec_i, vec_i} >> ptr_i;
        rot     = dbl[EV_W-1:0];
        lowest  = rot & (~rot + EV_W'(1));
        found_o = |vec_i;
        // 4-bit add wraps, undoing the rotation mod 16
        idx_o   = onehot_to_idx(lowest) + ptr_i;
    end

endmodule

// File: rtl/event_encoder16.sv
// Collects one-cycle event strobes into a pending register and emits one encoded index per
// accepted cycle, using fixed-priority or round-robin selection.
module event_encoder16
    import event_encoder16_pkg::*;
#(
    parameter int unsigned RR_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [EV_W-1:0]  req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [EV_W-1:0]  pend,
    output logic             overflow
);

    logic [EV_W-1:0]  pend_q, pend_d;
    logic [EV_W-1:0]  clr;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             overflow_q, overflow_d;
    logic [IDX_W-1:0] search_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             load;
    logic             grant;

    assign search_ptr = (RR_MODE != 0) ? ptr_q : '0;

    ffs16_rot u_ffs (
        .vec_i   (pend_q),
        .ptr_i   (search_ptr),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    always_comb begin
        load  = !out_valid_q || out_ready;
        grant = load && sel_found;
        clr   = '0;
        if (grant) begin
            clr = EV_W'(1) << sel_idx;
        end
        // A new strobe on the bit being cleared survives as a fresh event.
        pend_d      = (pend_q & ~clr) | req;
        overflow_d  = |(req & pend_q & ~clr);
        out_valid_d = load ? sel_found : out_valid_q;
        out_idx_d   = grant ? sel_idx : out_idx_q;
        ptr_d       = ptr_q;
        if (grant && (RR_MODE != 0)) begin
            ptr_d = sel_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            ptr_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            ptr_q       <= ptr_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pend      = pend_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_event_encoder16.sv
// Bench for event_encoder16: fixed and round-robin instances share one stimulus stream.
module tb_event_encoder16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        out_ready = 1'b0;

    logic        fx_valid, rr_valid;
    logic [3:0]  fx_idx, rr_idx;
    logic [15:0] fx_pend, rr_pend;
    logic        fx_ovf, rr_ovf;

    event_encoder16 #(.RR_MODE(0)) dut_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (fx_valid),
        .out_idx   (fx_idx),
        .pend      (fx_pend),
        .overflow  (fx_ovf)
    );

    event_encoder16 #(.RR_MODE(1)) dut_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (rr_valid),
        .out_idx   (rr_idx),
        .pend      (rr_pend),
        .overflow  (rr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [3:0]  idx;
        logic [15:0] pend;
        logic        ovf;
    } obs_t;

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        obs_t        exp;
    } vec_t;

    vec_t        tbl[$];
    obs_t        sb_q[$];
    logic [15:0] m_pend[2];
    logic        m_valid[2];
    logic [3:0]  m_idx[2];
    logic [3:0]  m_ptr[2];
    logic        m_ovf[2];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic obs_t get_obs(input int inst);
        obs_t o;
        if (inst == 0) o = {fx_valid, fx_idx, fx_pend, fx_ovf};
        else           o = {rr_valid, rr_idx, rr_pend, rr_ovf};
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got valid=%0b idx=%0d pend=%04h ovf=%0b, want valid=%0b idx=%0d pend=%04h ovf=%0b",
                     name, $time, act.valid, act.idx, act.pend, act.ovf,
                     exp.valid, exp.idx, exp.pend, exp.ovf);
        end
    endtask

    task automatic add_vec(input logic [15:0] r, input logic rdy, input logic v,
                           input logic [3:0] idx, input logic [15:0] p, input logic ovf);
        vec_t t;
        t.req = r;
        t.rdy = rdy;
        t.exp = {v, idx, p, ovf};
        tbl.push_back(t);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = '0;
            m_valid[i] = 1'b0;
            m_idx[i]   = '0;
            m_ptr[i]   = '0;
            m_ovf[i]   = 1'b0;
        end
        sb_q.delete();
    endtask

    // Behavioural reference: linear search from the pointer, one grant per loaded cycle.
    task automatic model_step(input logic [15:0] r, input logic rdy);
        logic        load;
        logic        found;
        logic [3:0]  k;
        logic [15:0] clr;
        int          base;
        int          j;
        for (int i = 0; i < 2; i++) begin
            load  = !m_valid[i] || rdy;
            found = 1'b0;
            k     = '0;
            base  = (i == 1) ? int'(m_ptr[i]) : 0;
            for (int s = 0; s < 16; s++) begin
                j = (base + s) % 16;
                if (!found && m_pend[i][j]) begin
                    found = 1'b1;
                    k     = 4'(j);
                end
            end
            clr = '0;
            if (load && found) clr[k] = 1'b1;
            m_ovf[i] = |(r & m_pend[i] & ~clr);
            if (load) begin
                m_valid[i] = found;
                if (found) m_idx[i] = k;
            end
            if (load && found && i == 1) m_ptr[i] = k + 4'd1;
            m_pend[i] = (m_pend[i] & ~clr) | r;
            sb_q.push_back({m_valid[i], m_idx[i], m_pend[i], m_ovf[i]});
        end
    endtask

    // Drive one cycle of stimulus, then compare both instances against the scoreboard.
    task automatic cycle(input logic [15:0] r, input logic rdy);
        req       = r;
        out_ready = rdy;
        model_step(r, rdy);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: got no expected entry, want one per instance");
            end else begin
                n_checks--;
                check(i == 0 ? "sb_fx" : "sb_rr", get_obs(i), sb_q.pop_front());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rr_exp[4];
        logic [15:0] r;

        // Fixed-mode vectors from reset: req, rdy, then valid, idx, pend, ovf after the edge.
        add_vec(16'h0020, 1, 0, 4'd0,  16'h0020, 0);  // single event
        add_vec(16'h0000, 1, 1, 4'd5,  16'h0000, 0);
        add_vec(16'h0000, 1, 0, 4'd5,  16'h0000, 0);
        add_vec(16'h8101, 1, 0, 4'd5,  16'h8101, 0);  // fixed priority
        add_vec(16'h0000, 1, 1, 4'd0,  16'h8100, 0);
        add_vec(16'h0000, 1, 1, 4'd8,  16'h8000, 0);
        add_vec(16'h0000, 1, 1, 4'd15, 16'h0000, 0);
        add_vec(16'h0000, 1, 0, 4'd15, 16'h0000, 0);
        add_vec(16'h0008, 0, 0, 4'd15, 16'h0008, 0);  // backpressure
        add_vec(16'h0001, 0, 1, 4'd3,  16'h0001, 0);
        add_vec(16'h0000, 0, 1, 4'd3,  16'h0001, 0);
        add_vec(16'h0000, 0, 1, 4'd3,  16'h0001, 0);
        add_vec(16'h0000, 1, 1, 4'd0,  16'h0000, 0);
        add_vec(16'h0000, 1, 0, 4'd0,  16'h0000, 0);
        add_vec(16'h0004, 0, 0, 4'd0,  16'h0004, 0);  // overflow while stalled
        add_vec(16'h0010, 0, 1, 4'd2,  16'h0010, 0);
        add_vec(16'h0010, 0, 1, 4'd2,  16'h0010, 1);
        add_vec(16'h0000, 0, 1, 4'd2,  16'h0010, 0);
        add_vec(16'h0000, 1, 1, 4'd4,  16'h0000, 0);
        add_vec(16'h0000, 1, 0, 4'd4,  16'h0000, 0);
        add_vec(16'h0040, 1, 0, 4'd4,  16'h0040, 0);  // set wins over clear
        add_vec(16'h0040, 1, 1, 4'd6,  16'h0040, 0);
        add_vec(16'h0000, 1, 1, 4'd6,  16'h0000, 0);
        add_vec(16'h0000, 1, 0, 4'd6,  16'h0000, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_fx", get_obs(0), '0);
        check("reset_rr", get_obs(1), '0);
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            cycle(tbl[n].req, tbl[n].rdy);
            check($sformatf("tbl_%0d", n), get_obs(0), tbl[n].exp);
        end

        // Asynchronous reset between edges with everything pending.
        cycle(16'hFFFF, 1'b0);
        cycle(16'h0000, 1'b0);
        req = 16'hFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_fx", get_obs(0), '0);
        check("rst_async_rr", get_obs(1), '0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_fx", get_obs(0), '0);
        req = 16'h0000;
        #2;
        rst_n = 1'b1;
        repeat (5) cycle(16'h0000, 1'b1);

        // Round-robin alternation with pend held at 0x0003.
        rr_exp[0] = 4'd0;
        rr_exp[1] = 4'd1;
        rr_exp[2] = 4'd0;
        rr_exp[3] = 4'd1;
        cycle(16'h0003, 1'b1);
        for (int g = 0; g < 4; g++) begin
            cycle(16'h0003, 1'b1);
            check($sformatf("rr_grant_%0d", g), get_obs(1), {1'b1, rr_exp[g], 16'h0003, 1'b1});
            check($sformatf("fx_grant_%0d", g), get_obs(0), {1'b1, 4'd0, 16'h0003, 1'b1});
        end

        // Random traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            cycle(r, $urandom_range(0, 3) != 0);
        end
        repeat (20) cycle(16'h0000, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
